// File: rtl/z_result_drain_if.sv
// rtl/z_result_drain_if.sv - ALU result offer and datapath bus handshake bundle
// slave is the drain; master is the producer/bus side that talks to it.
interface z_result_drain_if #(
    parameter int DATA_W = 32,
    parameter int OPC_W  = 5
);
    logic                  c_valid;
    logic                  c_ready;
    logic [2*DATA_W-1:0]   c_data;
    logic [OPC_W-1:0]      c_opcode;
    logic                  bus_valid;
    logic                  bus_ready;
    logic [DATA_W-1:0]     bus_out;
    logic [1:0]            dest_sel;

    modport slave (
        input  c_valid,
        input  c_data,
        input  c_opcode,
        input  bus_ready,
        output c_ready,
        output bus_valid,
        output bus_out,
        output dest_sel
    );

    modport master (
        output c_valid,
        output c_data,
        output c_opcode,
        output bus_ready,
        input  c_ready,
        input  bus_valid,
        input  bus_out,
        input  dest_sel
    );
endinterface

// File: rtl/z_result_drain.sv
// rtl/z_result_drain.sv - latches a 64-bit ALU result and sequences it onto the 32-bit bus
// Narrow ops write ZLo to Rz; mul/div write ZLo to LO then ZHi to HI; nop is dropped.
module z_result_drain #(
    parameter int               DATA_W  = 32,
    parameter int               OPC_W   = 5,
    parameter logic [OPC_W-1:0] OPC_MUL = 5'b10000,
    parameter logic [OPC_W-1:0] OPC_DIV = 5'b01111,
    parameter logic [OPC_W-1:0] OPC_NOP = 5'b11010
) (
    input  logic                clk_i,
    input  logic                rst_i,
    z_result_drain_if.slave     zif,
    output logic [DATA_W-1:0]   zhi_q_o,
    output logic [DATA_W-1:0]   zlo_q_o,
    output logic [15:0]         result_cnt_o
);

    localparam logic [1:0] DEST_RZ = 2'b00;
    localparam logic [1:0] DEST_LO = 2'b01;
    localparam logic [1:0] DEST_HI = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_EMIT_LO = 2'b01,
        S_EMIT_HI = 2'b10
    } state_e;

    state_e              state_q;
    logic                wide_q;
    logic                c_ready_q;
    logic                bus_valid_q;
    logic [DATA_W-1:0]   bus_out_q;
    logic [1:0]          dest_sel_q;
    logic [DATA_W-1:0]   zhi_q;
    logic [DATA_W-1:0]   zlo_q;
    logic [15:0]         result_cnt_q;

    logic                is_wide;
    logic                is_nop;

    assign is_wide = (zif.c_opcode == OPC_MUL) || (zif.c_opcode == OPC_DIV);
    assign is_nop  = (zif.c_opcode == OPC_NOP);

    // All bus-facing outputs are registered alongside the state so they stay
    // glitch-free and hold steady for as long as the destination stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            wide_q       <= 1'b0;
            c_ready_q    <= 1'b1;
            bus_valid_q  <= 1'b0;
            bus_out_q    <= '0;
            dest_sel_q   <= DEST_RZ;
            zhi_q        <= '0;
            zlo_q        <= '0;
            result_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (zif.c_valid && !is_nop) begin
                        zhi_q       <= zif.c_data[2*DATA_W-1:DATA_W];
                        zlo_q       <= zif.c_data[DATA_W-1:0];
                        wide_q      <= is_wide;
                        state_q     <= S_EMIT_LO;
                        c_ready_q   <= 1'b0;
                        bus_valid_q <= 1'b1;
                        bus_out_q   <= zif.c_data[DATA_W-1:0];
                        dest_sel_q  <= is_wide ? DEST_LO : DEST_RZ;
                    end
                end
                S_EMIT_LO: begin
                    if (zif.bus_ready) begin
                        if (wide_q) begin
                            state_q    <= S_EMIT_HI;
                            bus_out_q  <= zhi_q;
                            dest_sel_q <= DEST_HI;
                        end else begin
                            state_q      <= S_IDLE;
                            c_ready_q    <= 1'b1;
                            bus_valid_q  <= 1'b0;
                            bus_out_q    <= '0;
                            dest_sel_q   <= DEST_RZ;
                            result_cnt_q <= result_cnt_q + 16'd1;
                        end
                    end
                end
                S_EMIT_HI: begin
                    if (zif.bus_ready) begin
                        state_q      <= S_IDLE;
                        c_ready_q    <= 1'b1;
                        bus_valid_q  <= 1'b0;
                        bus_out_q    <= '0;
                        dest_sel_q   <= DEST_RZ;
                        result_cnt_q <= result_cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    c_ready_q   <= 1'b1;
                    bus_valid_q <= 1'b0;
                    bus_out_q   <= '0;
                    dest_sel_q  <= DEST_RZ;
                end
            endcase
        end
    end

    assign zif.c_ready   = c_ready_q;
    assign zif.bus_valid = bus_valid_q;
    assign zif.bus_out   = bus_out_q;
    assign zif.dest_sel  = dest_sel_q;
    assign zhi_q_o       = zhi_q;
    assign zlo_q_o       = zlo_q;
    assign result_cnt_o  = result_cnt_q;

endmodule

// File: tb/tb_z_result_drain.sv
// tb/tb_z_result_drain.sv - self-checking bench for z_result_drain
// Expected bus words come from a per-opcode word list built from the drain rules.
module tb_z_result_drain;

    localparam logic [4:0] OPC_MUL = 5'b10000;
    localparam logic [4:0] OPC_DIV = 5'b01111;
    localparam logic [4:0] OPC_NOP = 5'b11010;
    localparam logic [4:0] OPC_ADD = 5'b00011;

    logic        clk;
    logic        clear;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic [15:0] result_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] zhi_m;
    logic [31:0] zlo_m;
    logic [15:0] cnt_m;

    z_result_drain_if #(.DATA_W(32), .OPC_W(5)) zif ();

    z_result_drain dut (
        .clk_i        (clk),
        .rst_i        (clear),
        .zif          (zif),
        .zhi_q_o      (zhi),
        .zlo_q_o      (zlo),
        .result_cnt_o (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_c_ready"},   64'(zif.c_ready),   64'd1);
        chk({tag, "_bus_valid"}, 64'(zif.bus_valid), 64'd0);
        chk({tag, "_bus_out"},   64'(zif.bus_out),   64'd0);
        chk({tag, "_dest_sel"},  64'(zif.dest_sel),  64'd0);
        chk({tag, "_zhi"},       64'(zhi),           64'(zhi_m));
        chk({tag, "_zlo"},       64'(zlo),           64'(zlo_m));
        chk({tag, "_cnt"},       64'(result_cnt),    64'(cnt_m));
    endtask

    // Offer one result from IDLE, stall each bus word for `stall` cycles while
    // pulsing stray offers, then check the emitted words and final state.
    task automatic do_result(input string tag, input logic [4:0] opc,
                             input logic [63:0] data, input int stall);
        logic [31:0] ew[$];
        logic [1:0]  ed[$];
        if (opc == OPC_MUL || opc == OPC_DIV) begin
            ew.push_back(data[31:0]);  ed.push_back(2'b01);
            ew.push_back(data[63:32]); ed.push_back(2'b10);
        end else if (opc != OPC_NOP) begin
            ew.push_back(data[31:0]);  ed.push_back(2'b00);
        end

        chk({tag, "_pre_c_ready"}, 64'(zif.c_ready), 64'd1);
        zif.c_valid   = 1'b1;
        zif.c_data    = data;
        zif.c_opcode  = opc;
        zif.bus_ready = 1'b0;
        step();
        zif.c_valid = 1'b0;
        if (opc != OPC_NOP) begin
            zhi_m = data[63:32];
            zlo_m = data[31:0];
        end

        foreach (ew[i]) begin
            for (int s = 0; s < stall; s++) begin
                chk({tag, "_stall_valid"}, 64'(zif.bus_valid), 64'd1);
                chk({tag, "_stall_out"},   64'(zif.bus_out),   64'(ew[i]));
                chk({tag, "_stall_dest"},  64'(zif.dest_sel),  64'(ed[i]));
                chk({tag, "_stall_ready"}, 64'(zif.c_ready),   64'd0);
                zif.c_valid  = 1'($urandom_range(0, 1));
                zif.c_data   = {$urandom, $urandom};
                zif.c_opcode = 5'($urandom);
                step();
            end
            zif.c_valid   = 1'b0;
            zif.bus_ready = 1'b1;
            chk({tag, "_valid"}, 64'(zif.bus_valid), 64'd1);
            chk({tag, "_out"},   64'(zif.bus_out),   64'(ew[i]));
            chk({tag, "_dest"},  64'(zif.dest_sel),  64'(ed[i]));
            step();
            zif.bus_ready = 1'b0;
        end
        if (ew.size() != 0) cnt_m = cnt_m + 16'd1;
        chk_idle({tag, "_post"});
    endtask

    initial begin
        zif.c_valid   = 1'b0;
        zif.c_data    = '0;
        zif.c_opcode  = '0;
        zif.bus_ready = 1'b0;
        clear         = 1'b1;
        zhi_m = '0; zlo_m = '0; cnt_m = '0;
        repeat (2) step();
        chk_idle("reset");
        clear = 1'b0;
        step();
        chk_idle("after_reset");

        do_result("add",  OPC_ADD, 64'hFFFFFFFF_FFFFFFFE, 0);
        do_result("mul",  OPC_MUL, 64'h00000002_80000000, 0);
        do_result("div",  OPC_DIV, 64'hDEADBEEF_0BADF00D, 5);
        do_result("nop",  OPC_NOP, 64'h00000000_00001234, 0);
        do_result("misc", 5'b11111, 64'h01234567_89ABCDEF, 2);

        // Clear while the HI word of a mul is pending: it must never appear.
        zif.c_valid  = 1'b1;
        zif.c_data   = 64'hCAFEF00D_12345678;
        zif.c_opcode = OPC_MUL;
        step();
        zif.c_valid = 1'b0;
        chk("clr_lo_dest", 64'(zif.dest_sel), 64'd1);
        zif.bus_ready = 1'b1;
        step();
        zif.bus_ready = 1'b0;
        chk("clr_hi_dest", 64'(zif.dest_sel), 64'd2);
        chk("clr_hi_out",  64'(zif.bus_out),  64'hCAFEF00D);
        clear = 1'b1;
        step();
        clear = 1'b0;
        zhi_m = '0; zlo_m = '0; cnt_m = '0;
        chk_idle("clr");
        zif.bus_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("clr_no_emit", 64'(zif.bus_valid), 64'd0);
            step();
        end
        zif.bus_ready = 1'b0;

        for (int n = 0; n < 40; n++) begin
            logic [4:0] opc;
            case ($urandom_range(0, 5))
                0:       opc = OPC_MUL;
                1:       opc = OPC_DIV;
                2:       opc = OPC_NOP;
                default: opc = 5'($urandom);
            endcase
            do_result("rnd", opc, {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        // Reaching 16'hFFFF by 65535 transfers would take ~131k cycles, so
        // the counter is deposited there before the final wrapping result.
        force dut.result_cnt_q = 16'hFFFF;
        #1;
        release dut.result_cnt_q;
        cnt_m = 16'hFFFF;
        chk("wrap_preload", 64'(result_cnt), 64'hFFFF);
        do_result("wrap",      OPC_ADD, 64'h00000000_00000001, 0);
        chk("wrap_zero", 64'(result_cnt), 64'd0);
        do_result("wrap_next", OPC_ADD, 64'h00000000_00000002, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
